// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// default frame geometry and the idle level of the serial line.
// Build option: UART_RX_PARITY_EN adds a PARITY state (even parity bit).
package uart_pkg;

  localparam int   DEF_DATA_BITS  = 8;
  localparam int   DEF_OVERSAMPLE = 16;
  localparam logic LINE_IDLE      = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so a line can come out of reset already at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing, LSB first, with a
// one-entry output buffer.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and the rx_parity_err output.
//
// Output handshake: rx_valid=1 means rx_data holds an unread byte and
// rx_data is stable while rx_valid stays high. The byte is consumed on any
// clk edge where rx_valid & rx_ready. A frame finishing while the buffer is
// still full and not being consumed is dropped and flagged with rx_overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 rx_parity_err,
`endif
  output logic                 rx_overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 frame_done;
  logic                 frame_err_d;
  logic                 load;
  logic                 overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_q, parity_bad_d;
  logic                 parity_err_d;
`endif

  sync_2ff #(
    .RESET_VAL (LINE_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Next-state, counter and shift-register logic; everything moves on tick_baud only.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_prev_d   = tick_baud ? rx_s : rx_prev_q;
    frame_done  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    if (tick_baud) begin
      case (state_q)
        IDLE: begin
          // A start needs a high sample followed by a low one, so a line
          // stuck low never retriggers.
          if (!rx_s && rx_prev_q) begin
            tick_cnt_d = '0;
            state_d    = START;
          end
        end
        START: begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
              parity_bad_d = 1'b0;
`endif
              state_d    = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d                = '0;
            shift_d                   = shift_q >> 1;
            shift_d[DATA_BITS-1]      = rx_s;
            bit_cnt_d                 = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d   = '0;
            parity_bad_d = ^{shift_q, rx_s};
            parity_err_d = ^{shift_q, rx_s};
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              frame_done = !parity_bad_q;
`else
              frame_done = 1'b1;
`endif
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A finished frame goes into the buffer if it is empty or being drained this cycle.
  always_comb begin
    load      = frame_done && (!rx_valid || rx_ready);
    overrun_d = frame_done && rx_valid && !rx_ready;
  end

  // State, counters and the sampled-line history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_prev_q  <= LINE_IDLE;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_prev_q  <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  // Output buffer and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      if (load) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      rx_frame_err <= frame_err_d;
      rx_overrun   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= parity_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversampling, tick_baud every 4 clk,
// 64 clk per bit. Build option UART_RX_PARITY_EN also exercises parity.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       tick_baud;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  int valid_cycles = 0;
  int ferr_cnt     = 0;
  int ovr_cnt      = 0;
  int perr_cnt     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  int         tick_div = 0;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_baud    (tick_baud),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun   (rx_overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // baud tick: one clk wide, every 4 clk
  initial begin
    tick_baud = 1'b0;
    forever begin
      @(negedge clk);
      tick_baud = (tick_div == 3);
      tick_div  = (tick_div + 1) % 4;
    end
  end

  // monitor + scoreboard: counts pulses, checks each consumed byte
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (rx_valid)     valid_cycles++;
        if (rx_frame_err) ferr_cnt++;
        if (rx_overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (rx_parity_err) perr_cnt++;
`endif
        if (rx_valid && rx_ready) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_byte observed=%02h expected=none", rx_data);
          end
          if (exp_q.size() != 0) begin
            exp_byte = exp_q.pop_front();
            checks++;
            assert (rx_data === exp_byte) else begin
              errors++;
              $error("FAIL sb_byte observed=%02h expected=%02h", rx_data, exp_byte);
            end
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    valid_cycles = 0;
    ferr_cnt     = 0;
    ovr_cnt      = 0;
    perr_cnt     = 0;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    // reset state
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);

    // 0x55 with ready high: one valid cycle, no errors
    clear_counts();
    rx_ready = 1'b1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1);
    check("f55_valid_cycles", valid_cycles, 1);
    check("f55_consumed", exp_q.size(), 0);
    check("f55_ferr", ferr_cnt, 0);
    check("f55_ovr", ovr_cnt, 0);

    // 0xA3 unread, then 0x3C overruns
    clear_counts();
    rx_ready = 1'b0;
    send_frame(8'hA3, 1'b1);
    drive_bit(1'b1);
    check("a3_valid", rx_valid, 1);
    check("a3_data", rx_data, 32'hA3);
    check("a3_ovr_none", ovr_cnt, 0);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1);
    check("3c_ovr_pulse", ovr_cnt, 1);
    check("3c_data_kept", rx_data, 32'hA3);
    check("3c_valid_kept", rx_valid, 1);
    exp_q.push_back(8'hA3);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("a3_valid_cleared", rx_valid, 0);
    check("a3_consumed", exp_q.size(), 0);
    check("3c_ferr", ferr_cnt, 0);

    // false start: line low for 4 ticks only
    clear_counts();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);

    // 0xFF with low stop bit, line then held low two bit times
    clear_counts();
    send_frame(8'hFF, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("ff_ferr_once", ferr_cnt, 1);
    check("ff_no_valid", valid_cycles, 0);
    check("ff_ovr", ovr_cnt, 0);
    drive_bit(1'b1);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    check("12_after_err_valid", valid_cycles, 1);
    check("12_consumed", exp_q.size(), 0);
    check("12_ferr_still_one", ferr_cnt, 1);

    // reset during bit 3 of 0x81, then a clean 0x81
    clear_counts();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_ferr", rx_frame_err, 0);
    check("midrst_ovr", rx_overrun, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("postrst_ferr", ferr_cnt, 0);
    check("postrst_ovr", ovr_cnt, 0);
    check("postrst_valid", valid_cycles, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1);
    check("81_valid_cycles", valid_cycles, 1);
    check("81_consumed", exp_q.size(), 0);
    check("81_data", rx_data, 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 with wrong parity (0), then correct parity (1)
    clear_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("p07_bad_perr", perr_cnt, 1);
    check("p07_bad_no_valid", valid_cycles, 0);
    check("p07_bad_ferr", ferr_cnt, 0);
    clear_counts();
    exp_q.push_back(8'h07);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("p07_good_perr", perr_cnt, 0);
    check("p07_good_valid", valid_cycles, 1);
    check("p07_good_consumed", exp_q.size(), 0);
`endif

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: tick_baud pulses per bit period; even, >= 8.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port tick_baud  input  1  oversample strobe, one clk wide.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  DATA_BITS  received byte, stable while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  output buffer holds an unread byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-010 SHALL have port rx_frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 SHALL have port rx_overrun  output  1  one-clk pulse: completed frame dropped, buffer full.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (rx_s); reset value of both flops 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; all counters advance only on tick_baud.
REQ-014 IDLE: on tick with rx_s=0 and previous sampled rx_s=1 (falling edge), clear tick counter, go START.
REQ-015 START: on tick count OVERSAMPLE/2-1 sample rx_s; 0 -> clear counters, go DATA; 1 -> false start, go IDLE.
REQ-016 DATA: every OVERSAMPLE ticks sample rx_s into shift register MSB, shift right; after DATA_BITS samples go STOP.
REQ-017 STOP: after OVERSAMPLE ticks sample rx_s; 1 -> frame complete; 0 -> rx_frame_err pulse, frame discarded.
REQ-018 Both frame-complete and frame-error SHALL return to IDLE; a new start needs rx_s=1 then 0 (line held low never restarts).
REQ-019 Frame complete with buffer empty, or with rx_valid & rx_ready that cycle: load rx_data, rx_valid=1 on next clk.
REQ-020 Frame complete while rx_valid=1 and rx_ready=0: rx_overrun pulse, rx_data unchanged, frame dropped.
REQ-021 rx_valid SHALL clear the clk after rx_valid & rx_ready unless REQ-019 reloads that same cycle.
REQ-022 Ticks with rx_s changing mid-bit SHALL have no effect; only the centre sample counts.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, counters 0, shift register 0, rx_data 0, rx_valid 0, rx_frame_err 0, rx_overrun 0, synchronizer 1.
REQ-024 Reset mid-frame SHALL abandon the frame; no error or overrun pulse.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: state PARITY between DATA and STOP, one extra bit, even parity; output rx_parity_err (1 bit, one-clk pulse, reset 0); mismatch discards frame, still goes through STOP.
REQ-026 Macro undefined: no PARITY state, no rx_parity_err port, frame = start + DATA_BITS + stop.

Structure
REQ-027 Shared package uart_pkg SHALL hold the rx state enum, default DATA_BITS/OVERSAMPLE constants, idle line level.
REQ-028 Synchronizer SHALL be sub-module sync_2ff (parameterised reset value); counters and FSM stay in uart_rx.

Verification (OVERSAMPLE=16, tick_baud every 4 clk, 64 clk/bit)
REQ-029 Frame 0x55, rx_ready=1 -> rx_valid high exactly 1 clk, rx_data=0x55, no error pulses.
REQ-030 Frame 0xA3, rx_ready=0, then frame 0x3C -> rx_overrun 1 clk at second stop sample, rx_data stays 0xA3; ready then -> valid clears.
REQ-031 Idle line pulsed low 4 ticks -> START samples 1, back to IDLE, no rx_valid, no errors.
REQ-032 Frame 0xFF with stop bit 0, line held low 2 bit times -> one rx_frame_err pulse, no rx_valid, no restart until line high then low.
REQ-033 rst_n low during bit 3 of 0x81, released, then clean frame 0x81 -> outputs 0 during reset, then rx_data=0x81 valid.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07 valid.
